// File: rtl/axi_burst_check_pkg.sv
// Shared FSM state, AXI constants and saturating counter helper for the AXI burst generator/checker.
package axi_burst_check_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AW,
      ST_W,
      ST_B,
      ST_AR,
      ST_R,
      ST_DONE
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // Saturates at all-ones of the low `width` bits; callers cast back to their own width.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int width);
      logic [63:0] top;
      top = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      return (v >= top) ? top : v + 64'd1;
   endfunction

endpackage

// File: rtl/axi_burst_check_pattern.sv
// Address-derived test pattern: word index of the byte address, xored with the run seed.
module axi_burst_check_pattern #(
   parameter int AXI_ADDR_WIDTH = 21,
   parameter int AXI_DATA_WIDTH = 16
) (
   input  logic [AXI_ADDR_WIDTH-1:0] addr,
   input  logic [AXI_DATA_WIDTH-1:0] seed,
   output logic [AXI_DATA_WIDTH-1:0] data
);

   localparam int LSB = $clog2(AXI_DATA_WIDTH / 8);

   logic [AXI_ADDR_WIDTH-1:0] word_idx;

   assign word_idx = addr >> LSB;
   assign data     = AXI_DATA_WIDTH'(word_idx) ^ seed;

endmodule

// File: rtl/axi_burst_check_gen.sv
// AXI4 burst traffic generator/checker: writes N INCR bursts of a pattern, reads them back, counts errors.
// Define AXI_BURST_CHECK_ERR_CAPTURE_EN to add capture of the first failing read beat.
module axi_burst_check_gen
   import axi_burst_check_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 21,
   parameter int AXI_DATA_WIDTH = 16,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int STAT_WIDTH     = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [AXI_ADDR_WIDTH-1:0]   base_addr,
   input  logic [7:0]                  burst_len,
   input  logic [15:0]                 burst_count,
   input  logic [AXI_DATA_WIDTH-1:0]   seed,
   output logic                        busy,
   output logic                        done,
   output logic [STAT_WIDTH-1:0]       err_cnt,
   output logic [STAT_WIDTH-1:0]       cyc_cnt,
`ifdef AXI_BURST_CHECK_ERR_CAPTURE_EN
   output logic [AXI_ADDR_WIDTH-1:0]   first_err_addr,
   output logic [AXI_DATA_WIDTH-1:0]   first_err_data,
   output logic                        first_err_valid,
`endif
   output logic                        m_axi_awvalid,
   input  logic                        m_axi_awready,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]                  m_axi_awlen,
   output logic [2:0]                  m_axi_awsize,
   output logic [1:0]                  m_axi_awburst,
   output logic                        m_axi_wvalid,
   input  logic                        m_axi_wready,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                        m_axi_wlast,
   input  logic                        m_axi_bvalid,
   output logic                        m_axi_bready,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
   input  logic [1:0]                  m_axi_bresp,
   output logic                        m_axi_arvalid,
   input  logic                        m_axi_arready,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]                  m_axi_arlen,
   output logic [2:0]                  m_axi_arsize,
   output logic [1:0]                  m_axi_arburst,
   input  logic                        m_axi_rvalid,
   output logic                        m_axi_rready,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
   input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp,
   input  logic                        m_axi_rlast
);

   localparam int LSB = $clog2(AXI_DATA_WIDTH / 8);

   state_t                    state, state_nx;
   logic [AXI_ADDR_WIDTH-1:0] base_r, burst_addr, beat_addr, stride;
   logic [AXI_DATA_WIDTH-1:0] seed_r, pattern;
   logic [7:0]                len_r, beat;
   logic [15:0]               count_r, bursts_left;
   logic                      last_beat, last_burst, r_bad;
   logic                      unused_ids;

   // Only one transaction is ever in flight, so returned IDs carry no information.
   assign unused_ids = ^{m_axi_bid, m_axi_rid};

   assign stride     = AXI_ADDR_WIDTH'({1'b0, len_r} + 9'd1) << LSB;
   assign beat_addr  = burst_addr + (AXI_ADDR_WIDTH'(beat) << LSB);
   assign last_beat  = (beat == len_r);
   assign last_burst = (bursts_left == 16'd1);
   assign r_bad      = (m_axi_rdata != pattern) || (m_axi_rresp != AXI_RESP_OKAY) ||
                       (m_axi_rlast != last_beat);

   axi_burst_check_pattern #(
      .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
      .AXI_DATA_WIDTH(AXI_DATA_WIDTH)
   ) u_pattern (
      .addr(beat_addr),
      .seed(seed_r),
      .data(pattern)
   );

   assign m_axi_awid    = '0;
   assign m_axi_awaddr  = burst_addr;
   assign m_axi_awlen   = len_r;
   assign m_axi_awsize  = 3'(LSB);
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_wdata   = pattern;
   assign m_axi_wstrb   = '1;
   assign m_axi_wlast   = last_beat;
   assign m_axi_arid    = '0;
   assign m_axi_araddr  = burst_addr;
   assign m_axi_arlen   = len_r;
   assign m_axi_arsize  = 3'(LSB);
   assign m_axi_arburst = AXI_BURST_INCR;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_nx = (burst_count != 16'd0) ? ST_AW : ST_DONE;
         end
         ST_AW: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) state_nx = ST_W;
         end
         ST_W: begin
            m_axi_wvalid = 1'b1;
            if (m_axi_wready && last_beat) state_nx = ST_B;
         end
         ST_B: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) state_nx = last_burst ? ST_AR : ST_AW;
         end
         ST_AR: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) state_nx = ST_R;
         end
         ST_R: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid && last_beat) state_nx = last_burst ? ST_DONE : ST_AR;
         end
         ST_DONE: begin
            busy     = 1'b0;
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_r      <= '0;
         burst_addr  <= '0;
         seed_r      <= '0;
         len_r       <= '0;
         beat        <= '0;
         count_r     <= '0;
         bursts_left <= '0;
         err_cnt     <= '0;
         cyc_cnt     <= '0;
`ifdef AXI_BURST_CHECK_ERR_CAPTURE_EN
         first_err_addr  <= '0;
         first_err_data  <= '0;
         first_err_valid <= 1'b0;
`endif
      end else begin
         if (busy) cyc_cnt <= STAT_WIDTH'(sat_inc(64'(cyc_cnt), STAT_WIDTH));
         case (state)
            ST_IDLE: if (start) begin
               base_r      <= base_addr;
               burst_addr  <= base_addr;
               seed_r      <= seed;
               len_r       <= burst_len;
               count_r     <= burst_count;
               bursts_left <= burst_count;
               beat        <= '0;
               err_cnt     <= '0;
               cyc_cnt     <= '0;
`ifdef AXI_BURST_CHECK_ERR_CAPTURE_EN
               first_err_addr  <= '0;
               first_err_data  <= '0;
               first_err_valid <= 1'b0;
`endif
            end
            ST_W: if (m_axi_wready) beat <= last_beat ? 8'd0 : beat + 8'd1;
            ST_B: if (m_axi_bvalid) begin
               if (m_axi_bresp != AXI_RESP_OKAY)
                  err_cnt <= STAT_WIDTH'(sat_inc(64'(err_cnt), STAT_WIDTH));
               // Read phase replays the same region from the start.
               if (last_burst) begin
                  burst_addr  <= base_r;
                  bursts_left <= count_r;
               end else begin
                  burst_addr  <= burst_addr + stride;
                  bursts_left <= bursts_left - 16'd1;
               end
            end
            ST_R: if (m_axi_rvalid) begin
               if (r_bad) begin
                  err_cnt <= STAT_WIDTH'(sat_inc(64'(err_cnt), STAT_WIDTH));
`ifdef AXI_BURST_CHECK_ERR_CAPTURE_EN
                  if (!first_err_valid) begin
                     first_err_addr  <= beat_addr;
                     first_err_data  <= m_axi_rdata;
                     first_err_valid <= 1'b1;
                  end
`endif
               end
               if (last_beat) begin
                  beat        <= '0;
                  burst_addr  <= burst_addr + stride;
                  bursts_left <= bursts_left - 16'd1;
               end else begin
                  beat <= beat + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_burst_check_gen.sv
// Self-checking bench: reactive AXI slave with fault injection plus a run-level error/beat model.
`timescale 1ns/1ps
module tb_axi_burst_check_gen;

   localparam int AW = 21, DW = 16, IW = 4, SW = 32;

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [7:0]    burst_len = '0;
   logic [15:0]   burst_count = '0;
   logic [DW-1:0] seed = '0;
   logic          busy, done;
   logic [SW-1:0] err_cnt, cyc_cnt;
`ifdef AXI_BURST_CHECK_ERR_CAPTURE_EN
   logic [AW-1:0] first_err_addr;
   logic [DW-1:0] first_err_data;
   logic          first_err_valid;
`endif
   logic          m_axi_awvalid, m_axi_awready = 1'b0;
   logic [IW-1:0] m_axi_awid, m_axi_arid;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [7:0]    m_axi_awlen, m_axi_arlen;
   logic [2:0]    m_axi_awsize, m_axi_arsize;
   logic [1:0]    m_axi_awburst, m_axi_arburst;
   logic          m_axi_wvalid, m_axi_wready = 1'b0, m_axi_wlast;
   logic [DW-1:0] m_axi_wdata;
   logic [1:0]    m_axi_wstrb;
   logic          m_axi_bvalid = 1'b0, m_axi_bready;
   logic [IW-1:0] m_axi_bid = '0, m_axi_rid = '0;
   logic [1:0]    m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
   logic          m_axi_arvalid, m_axi_arready = 1'b0;
   logic          m_axi_rvalid = 1'b0, m_axi_rready, m_axi_rlast = 1'b0;
   logic [DW-1:0] m_axi_rdata = '0;

   always #5 clk = ~clk;

   axi_burst_check_gen #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .STAT_WIDTH(SW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .burst_len(burst_len),
      .burst_count(burst_count), .seed(seed), .busy(busy), .done(done), .err_cnt(err_cnt), .cyc_cnt(cyc_cnt),
`ifdef AXI_BURST_CHECK_ERR_CAPTURE_EN
      .first_err_addr(first_err_addr), .first_err_data(first_err_data), .first_err_valid(first_err_valid),
`endif
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awid(m_axi_awid),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_awburst(m_axi_awburst), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bid(m_axi_bid),
      .m_axi_bresp(m_axi_bresp), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
      .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
   );

   int n_checks = 0, n_pass = 0;

   // Run description shared with the slave: bit0 corrupt data, bit1 SLVERR, bit2 flip rlast.
   logic [AW-1:0] cur_base = '0;
   int            cur_len = 0, cur_count = 0;
   logic [DW-1:0] cur_seed = '0;
   bit            thr = 1'b0;
   bit            b_bad [16];
   bit [2:0]      r_fault [16][16];
   int            wr_beats = 0, rd_beats = 0, wr_burst = 0, rd_burst = 0;
   bit            any_valid = 1'b0;
   logic [DW-1:0] mem [int];

   function automatic logic [AW-1:0] exp_burst_addr(int idx);
      return AW'(32'(cur_base) + 32'(idx * (cur_len + 1) * 2));
   endfunction

   function automatic int model_err(int len, int count);
      int e = 0;
      for (int i = 0; i < count; i++) begin
         if (b_bad[i]) e++;
         for (int j = 0; j <= len; j++) if (r_fault[i][j] != 3'd0) e++;
      end
      return e;
   endfunction

   task automatic clear_faults();
      for (int i = 0; i < 16; i++) begin
         b_bad[i] = 1'b0;
         for (int j = 0; j < 16; j++) r_fault[i][j] = 3'd0;
      end
   endtask

   // Reactive slave: drives after each rising edge, observes handshakes on the falling edge.
   initial begin : slave
      logic [AW-1:0] w_base, r_base, a;
      logic [28:0]   aw_hold, ar_hold;
      logic [16:0]   w_hold;
      logic [DW-1:0] exp_w;
      bit [2:0]      f;
      int            w_beat, r_beat, r_len;
      bit            r_active, b_pend, aw_stall, ar_stall, w_stall;
      w_base = '0; r_base = '0; aw_hold = '0; ar_hold = '0; w_hold = '0;
      w_beat = 0; r_beat = 0; r_len = 0;
      r_active = 0; b_pend = 0; aw_stall = 0; ar_stall = 0; w_stall = 0;
      forever begin
         @(posedge clk); #1;
         m_axi_awready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axi_wready  = thr ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axi_arready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axi_bvalid  = b_pend;
         m_axi_bresp   = b_bad[wr_burst % 16] ? 2'b10 : 2'b00;
         m_axi_rvalid  = r_active && (thr ? 1'($urandom_range(0, 1)) : 1'b1);
         a = AW'(32'(r_base) + 32'(r_beat * 2));
         f = r_fault[rd_burst % 16][r_beat % 16];
         m_axi_rdata = (r_active && mem.exists(int'(a))) ? (mem[int'(a)] ^ (f[0] ? 16'h0001 : 16'h0000)) : '0;
         m_axi_rresp = f[1] ? 2'b10 : 2'b00;
         m_axi_rlast = (r_beat == r_len) ^ f[2];
         @(negedge clk);
         if (rst) begin
            r_active = 0; b_pend = 0; aw_stall = 0; ar_stall = 0; w_stall = 0; w_beat = 0;
            continue;
         end
         if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) any_valid = 1'b1;
         if (aw_stall) begin
            n_checks++;
            if ({m_axi_awvalid, m_axi_awaddr, m_axi_awlen} !== {1'b1, aw_hold})
               $display("FAIL aw_stable got %b/%h/%0d want held %h", m_axi_awvalid, m_axi_awaddr, m_axi_awlen, aw_hold);
            else n_pass++;
         end
         if (ar_stall) begin
            n_checks++;
            if ({m_axi_arvalid, m_axi_araddr, m_axi_arlen} !== {1'b1, ar_hold})
               $display("FAIL ar_stable got %b/%h/%0d want held %h", m_axi_arvalid, m_axi_araddr, m_axi_arlen, ar_hold);
            else n_pass++;
         end
         if (w_stall) begin
            n_checks++;
            if ({m_axi_wvalid, m_axi_wdata, m_axi_wlast} !== {1'b1, w_hold})
               $display("FAIL w_stable got %b/%h/%b want held %h", m_axi_wvalid, m_axi_wdata, m_axi_wlast, w_hold);
            else n_pass++;
         end
         aw_stall = m_axi_awvalid && !m_axi_awready; aw_hold = {m_axi_awaddr, m_axi_awlen};
         ar_stall = m_axi_arvalid && !m_axi_arready; ar_hold = {m_axi_araddr, m_axi_arlen};
         w_stall  = m_axi_wvalid && !m_axi_wready;   w_hold  = {m_axi_wdata, m_axi_wlast};
         if (m_axi_awvalid && m_axi_awready) begin
            n_checks++;
            if ({m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid} !==
                {exp_burst_addr(wr_burst), 8'(cur_len), 3'd1, 2'b01, 4'd0})
               $display("FAIL aw_payload got addr %h len %0d size %0d burst %0d id %0d want addr %h len %0d",
                        m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid,
                        exp_burst_addr(wr_burst), cur_len);
            else n_pass++;
            w_base = m_axi_awaddr; w_beat = 0;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            a = AW'(32'(w_base) + 32'(w_beat * 2));
            exp_w = DW'(a >> 1) ^ cur_seed;
            n_checks++;
            if ({m_axi_wdata, m_axi_wlast, m_axi_wstrb} !== {exp_w, (w_beat == cur_len), 2'b11})
               $display("FAIL w_beat @%h got data %h last %b strb %b want data %h last %b",
                        a, m_axi_wdata, m_axi_wlast, m_axi_wstrb, exp_w, (w_beat == cur_len));
            else n_pass++;
            mem[int'(a)] = m_axi_wdata;
            if (w_beat == cur_len) b_pend = 1'b1;
            w_beat++; wr_beats++;
         end
         if (m_axi_bvalid && m_axi_bready) begin
            b_pend = 1'b0; wr_burst++;
         end
         if (m_axi_arvalid && m_axi_arready) begin
            n_checks++;
            if ({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid} !==
                {exp_burst_addr(rd_burst), 8'(cur_len), 3'd1, 2'b01, 4'd0})
               $display("FAIL ar_payload got addr %h len %0d want addr %h len %0d",
                        m_axi_araddr, m_axi_arlen, exp_burst_addr(rd_burst), cur_len);
            else n_pass++;
            r_base = m_axi_araddr; r_beat = 0; r_len = int'(m_axi_arlen); r_active = 1'b1;
         end
         if (m_axi_rvalid && m_axi_rready) begin
            rd_beats++;
            if (r_beat == r_len) begin r_active = 1'b0; rd_burst++; end
            else r_beat++;
         end
      end
   end

   task automatic do_start(input logic [AW-1:0] b, input int len, input int count, input logic [DW-1:0] s);
      cur_base = b; cur_len = len; cur_count = count; cur_seed = s;
      wr_beats = 0; rd_beats = 0; wr_burst = 0; rd_burst = 0; any_valid = 1'b0;
      base_addr = b; burst_len = 8'(len); burst_count = 16'(count); seed = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen, output int cycles);
      seen = 1'b0; cycles = 0;
      for (int i = 0; i < budget; i++) begin
         if (done) begin seen = 1'b1; break; end
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, err_cnt, cyc_cnt} !== '0) $display("FAIL reset_status got busy %b done %b err %0d cyc %0d want 0", busy, done, err_cnt, cyc_cnt);
      else n_pass++;
      n_checks++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0)
         $display("FAIL reset_valids got %b want 00000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
      else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Zero-latency slave: every burst costs AW + B + AR (3 cycles) plus 2*(len+1) data beats.
   task automatic run_ideal(input string name, input logic [AW-1:0] b, input int len, input int count, input logic [DW-1:0] s);
      bit seen; int cyc;
      thr = 1'b0;
      do_start(b, len, count, s);
      wait_done(4000, seen, cyc);
      n_checks++;
      if (!seen) $display("FAIL %s_done timeout after %0d cycles", name, cyc); else n_pass++;
      n_checks++;
      if ({busy, err_cnt} !== {1'b0, 32'(model_err(len, count))})
         $display("FAIL %s_err got busy %b err %0d want busy 0 err %0d", name, busy, err_cnt, model_err(len, count));
      else n_pass++;
      n_checks++;
      if (cyc_cnt !== 32'(count * (2 * len + 5))) $display("FAIL %s_cyc got %0d want %0d", name, cyc_cnt, count * (2 * len + 5));
      else n_pass++;
      n_checks++;
      if (wr_beats != count * (len + 1) || rd_beats != count * (len + 1))
         $display("FAIL %s_beats got wr %0d rd %0d want %0d", name, wr_beats, rd_beats, count * (len + 1));
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if ({done, busy} !== 2'b00) $display("FAIL %s_done_pulse got done %b busy %b want 0 0", name, done, busy);
      else n_pass++;
   endtask

   task automatic test_basic();
      clear_faults();
      run_ideal("basic", 21'h000, 3, 2, 16'h0000);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (cyc_cnt !== 32'd22) $display("FAIL basic_hold got cyc %0d want 22", cyc_cnt); else n_pass++;
   endtask

   task automatic test_wrap();
      clear_faults();
      run_ideal("wrap", 21'h1FFFF8, 3, 2, 16'hA5C3);
   endtask

   task automatic test_corrupt();
      clear_faults();
      r_fault[1][2] = 3'b001;
      run_ideal("corrupt", 21'h000, 3, 2, 16'h0000);
`ifdef AXI_BURST_CHECK_ERR_CAPTURE_EN
      n_checks++;
      if ({first_err_valid, first_err_addr, first_err_data} !== {1'b1, 21'h00C, 16'h0007})
         $display("FAIL capture got v %b addr %h data %h want 1 00c 0007", first_err_valid, first_err_addr, first_err_data);
      else n_pass++;
`endif
   endtask

   task automatic test_resp_errors();
      clear_faults();
      for (int i = 0; i < 3; i++) b_bad[i] = 1'b1;
      run_ideal("bresp", 21'h080, 1, 3, 16'h1234);
      clear_faults();
      for (int i = 0; i < 4; i++) begin
         b_bad[i] = (i != 0);
         r_fault[i][0] = 3'b010;
      end
      run_ideal("rresp", 21'h100, 0, 4, 16'h0F0F);
      clear_faults();
      r_fault[0][1] = 3'b100;
      r_fault[1][0] = 3'b111;
      run_ideal("rlast", 21'h200, 2, 2, 16'h8001);
`ifdef AXI_BURST_CHECK_ERR_CAPTURE_EN
      clear_faults();
      run_ideal("clean", 21'h300, 1, 1, 16'h0000);
      n_checks++;
      if (first_err_valid !== 1'b0) $display("FAIL capture_clear got %b want 0", first_err_valid); else n_pass++;
`endif
   endtask

   task automatic test_throttle_random();
      bit seen; int cyc, len, count, e;
      logic [AW-1:0] b;
      for (int it = 0; it < 8; it++) begin
         clear_faults();
         len = $urandom_range(0, 7); count = $urandom_range(1, 4);
         b = AW'($urandom) & ~21'h1;
         for (int i = 0; i < count; i++) begin
            b_bad[i] = ($urandom_range(0, 5) == 0);
            for (int j = 0; j <= len; j++)
               r_fault[i][j] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         end
         e = model_err(len, count);
         thr = 1'b1;
         do_start(b, len, count, DW'($urandom));
         wait_done(4000, seen, cyc);
         n_checks++;
         if (!seen) $display("FAIL rand%0d_done timeout after %0d cycles", it, cyc); else n_pass++;
         n_checks++;
         if (err_cnt !== 32'(e)) $display("FAIL rand%0d_err got %0d want %0d", it, err_cnt, e); else n_pass++;
         n_checks++;
         if (rd_beats != count * (len + 1) || cyc_cnt < 32'(count * (2 * len + 5)))
            $display("FAIL rand%0d_beats got rd %0d cyc %0d want rd %0d cyc>=%0d", it, rd_beats, cyc_cnt,
                     count * (len + 1), count * (2 * len + 5));
         else n_pass++;
         @(posedge clk); #1;
      end
      thr = 1'b0;
   endtask

   task automatic test_zero_count();
      bit seen, was_busy; int cyc;
      clear_faults();
      do_start(21'h040, 3, 0, 16'h0000);
      seen = 1'b0; was_busy = 1'b0; cyc = 0;
      for (int i = 0; i < 2 && !seen; i++) begin
         if (busy) was_busy = 1'b1;
         if (done) seen = 1'b1;
         else begin @(posedge clk); #1; cyc++; end
      end
      n_checks++;
      if (!seen || was_busy) $display("FAIL zero_done got done %b busy_seen %b want 1 0", seen, was_busy); else n_pass++;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if ({any_valid, busy, done} !== 3'b000) $display("FAIL zero_quiet got valid %b busy %b done %b want 000", any_valid, busy, done);
      else n_pass++;
   endtask

   task automatic test_start_while_busy();
      bit seen; int cyc;
      clear_faults();
      thr = 1'b0;
      do_start(21'h400, 3, 2, 16'h00FF);
      repeat (4) @(posedge clk);
      #1;
      base_addr = 21'h0; burst_count = 16'd0; burst_len = 8'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(4000, seen, cyc);
      n_checks++;
      if (!seen || err_cnt !== 32'd0 || cyc_cnt !== 32'd22)
         $display("FAIL busy_start got done %b err %0d cyc %0d want 1 0 22", seen, err_cnt, cyc_cnt);
      else n_pass++;
      n_checks++;
      if (wr_beats != 8 || rd_beats != 8) $display("FAIL busy_start_beats got wr %0d rd %0d want 8 8", wr_beats, rd_beats);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit hit;
      clear_faults();
      thr = 1'b0;
      do_start(21'h040, 7, 2, 16'h3C3C);
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
         if (m_axi_wvalid) hit = 1'b1;
         else begin @(posedge clk); #1; end
      end
      n_checks++;
      if (!hit) $display("FAIL rstmid_wphase got no wvalid within 50 cycles"); else n_pass++;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, busy, done} !== 7'b0)
         $display("FAIL rstmid_abort got %b want 0000000",
                  {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, busy, done});
      else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
      run_ideal("after_rst", 21'h200, 1, 3, 16'h5555);
   endtask

   initial begin
      clear_faults();
      test_reset();
      test_basic();
      test_wrap();
      test_corrupt();
      test_resp_errors();
      test_throttle_random();
      test_zero_count();
      test_start_while_busy();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
